banco_registradores_8x: RTL and testbench

// - 8-entry register bank that consumes the one-hot write-enable vector

---
 rtl/banco_registradores_8x_pkg.sv | 12 +
 rtl/banco_registradores_8x_decodificador_3x8.sv | 17 +
 rtl/banco_registradores_8x.sv | 129 ++++++++++++
 tb/tb_banco_registradores_8x.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_8x_pkg.sv
// Shared sizes and FSM state codes for the 8-entry register bank.
package banco_registradores_8x_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned END_BITS = 3;

    typedef enum logic {
        OCIOSO   = 1'b0,
        LIMPANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/banco_registradores_8x_decodificador_3x8.sv
// 3-to-8 one-hot row decoder; all-zero output when not enabled.
module decodificador_3x8
    import banco_registradores_8x_pkg::*;
(
    input  logic [END_BITS-1:0] endereco,
    input  logic                habilita,
    output logic [NUM_REGS-1:0] linha_c
);

    always_comb begin
        linha_c = '0;
        if (habilita) begin
            linha_c[endereco] = 1'b1;
        end
    end

endmodule

// File: rtl/banco_registradores_8x.sv
// 8x register bank: one write port, two registered read ports with
// write-first bypass, and an FSM-sequenced clear-all.
module banco_registradores_8x
    import banco_registradores_8x_pkg::*;
#(
    parameter int unsigned LARGURA = 16,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                escreve,
    input  logic [END_BITS-1:0] end_escrita,
    input  logic [LARGURA-1:0]  dado_escrita,
    input  logic                le,
    input  logic [END_BITS-1:0] end_a,
    input  logic [END_BITS-1:0] end_b,
    output logic [LARGURA-1:0]  dado_a,
    output logic [LARGURA-1:0]  dado_b,
    output logic                dado_valido,
    input  logic                limpa,
    output logic                ocupado
);

    logic [LARGURA-1:0]  regs [NUM_REGS];
    estado_t             estado, estado_prox;
    logic [END_BITS-1:0] ponteiro, ponteiro_prox;
    logic                grava_c, leitura_c, limpando_c;
    logic [NUM_REGS-1:0] linha_escrita_c, linha_limpa_c;
    logic [LARGURA-1:0]  leitura_a_c, leitura_b_c;

    // FSM state and clear pointer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado   <= OCIOSO;
            ponteiro <= '0;
        end else begin
            estado   <= estado_prox;
            ponteiro <= ponteiro_prox;
        end
    end

    // Next state and per-cycle controls; limpa wins over escreve in OCIOSO
    always_comb begin
        estado_prox   = estado;
        ponteiro_prox = ponteiro;
        grava_c       = 1'b0;
        leitura_c     = 1'b0;
        limpando_c    = 1'b0;
        case (estado)
            OCIOSO: begin
                leitura_c = le;
                if (limpa) begin
                    estado_prox   = LIMPANDO;
                    ponteiro_prox = '0;
                end else begin
                    grava_c = escreve;
                end
            end
            LIMPANDO: begin
                limpando_c    = 1'b1;
                ponteiro_prox = END_BITS'(ponteiro + 1'b1);
                if (ponteiro == END_BITS'(NUM_REGS - 1)) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    decodificador_3x8 u_dec_escrita (
        .endereco (end_escrita),
        .habilita (grava_c),
        .linha_c  (linha_escrita_c)
    );

    decodificador_3x8 u_dec_limpa (
        .endereco (ponteiro),
        .habilita (limpando_c),
        .linha_c  (linha_limpa_c)
    );

    // Register array: clear row and write row are never active together
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (linha_limpa_c[i]) begin
                    regs[i] <= '0;
                end else if (linha_escrita_c[i]) begin
                    regs[i] <= dado_escrita;
                end
            end
        end
    end

    // Read muxes with write-first forwarding of an accepted write
    always_comb begin
        leitura_a_c = regs[end_a];
        leitura_b_c = regs[end_b];
        if (BYPASS && grava_c && (end_a == end_escrita)) begin
            leitura_a_c = dado_escrita;
        end
        if (BYPASS && grava_c && (end_b == end_escrita)) begin
            leitura_b_c = dado_escrita;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dado_a      <= '0;
            dado_b      <= '0;
            dado_valido <= 1'b0;
        end else begin
            dado_valido <= leitura_c;
            if (leitura_c) begin
                dado_a <= leitura_a_c;
                dado_b <= leitura_b_c;
            end
        end
    end

    assign ocupado = (estado == LIMPANDO);

endmodule

// File: tb/tb_banco_registradores_8x.sv
// Scoreboard bench for banco_registradores_8x against an array-based model.
module tb_banco_registradores_8x;

    localparam int unsigned LARGURA = 16;
    localparam bit          BYPASS  = 1'b1;

    logic               clock = 1'b0;
    logic               resetn;
    logic               escreve;
    logic [2:0]         end_escrita;
    logic [LARGURA-1:0] dado_escrita;
    logic               le;
    logic [2:0]         end_a;
    logic [2:0]         end_b;
    logic [LARGURA-1:0] dado_a;
    logic [LARGURA-1:0] dado_b;
    logic               dado_valido;
    logic               limpa;
    logic               ocupado;

    banco_registradores_8x #(.LARGURA(LARGURA), .BYPASS(BYPASS)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .escreve      (escreve),
        .end_escrita  (end_escrita),
        .dado_escrita (dado_escrita),
        .le           (le),
        .end_a        (end_a),
        .end_b        (end_b),
        .dado_a       (dado_a),
        .dado_b       (dado_b),
        .dado_valido  (dado_valido),
        .limpa        (limpa),
        .ocupado      (ocupado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [LARGURA-1:0] a;
        logic [LARGURA-1:0] b;
    } par_t;

    par_t               fila[$];
    logic [LARGURA-1:0] modelo [8];
    int                 ciclos_limpeza;
    int                 checks = 0;
    int                 errors = 0;

    task automatic confere(input string nome, input logic [LARGURA-1:0] obtido,
                           input logic [LARGURA-1:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, obtido, esperado);
        end
    endtask

    // One clock of stimulus; expected read data goes to the scoreboard queue
    task automatic passo(input bit es, input logic [2:0] ea, input logic [LARGURA-1:0] d,
                         input bit l, input logic [2:0] a, input logic [2:0] b, input bit lp);
        par_t e;
        bit   grava;
        escreve = es; end_escrita = ea; dado_escrita = d;
        le = l; end_a = a; end_b = b; limpa = lp;
        grava = es && !lp && (ciclos_limpeza == 0);
        if (ciclos_limpeza == 0 && l) begin
            e.a = (BYPASS && grava && ea == a) ? d : modelo[a];
            e.b = (BYPASS && grava && ea == b) ? d : modelo[b];
            fila.push_back(e);
        end
        @(posedge clock);
        if (ciclos_limpeza != 0) begin
            ciclos_limpeza--;
        end else if (lp) begin
            ciclos_limpeza = 8;
            for (int i = 0; i < 8; i++) modelo[i] = '0;
        end else if (es) begin
            modelo[ea] = d;
        end
        #1;
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) passo(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge
    task automatic aplica_reset();
        escreve = 0; le = 0; limpa = 0;
        #2 resetn = 1'b0;
        #1;
        confere("reset dado_a", dado_a, '0);
        confere("reset dado_b", dado_b, '0);
        confere("reset dado_valido", LARGURA'(dado_valido), '0);
        confere("reset ocupado", LARGURA'(ocupado), '0);
        fila.delete();
        for (int i = 0; i < 8; i++) modelo[i] = '0;
        ciclos_limpeza = 0;
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic le_todos();
        for (int i = 0; i < 8; i++) passo(0, 0, 0, 1, 3'(i), 3'(7 - i), 0);
    endtask

    // Monitor: pops on dado_valido, otherwise expects held outputs
    initial begin
        par_t               e;
        logic [LARGURA-1:0] ult_a = '0;
        logic [LARGURA-1:0] ult_b = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                ult_a = '0;
                ult_b = '0;
            end else begin
                confere("ocupado", LARGURA'(ocupado), LARGURA'(ciclos_limpeza != 0));
                if (dado_valido) begin
                    if (fila.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dado_valido: got 1 expected 0 (no read pending)");
                    end else begin
                        e = fila.pop_front();
                        confere("dado_a", dado_a, e.a);
                        confere("dado_b", dado_b, e.b);
                        ult_a = e.a;
                        ult_b = e.b;
                    end
                end else begin
                    confere("hold dado_a", dado_a, ult_a);
                    confere("hold dado_b", dado_b, ult_b);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        escreve = 0; end_escrita = 0; dado_escrita = 0;
        le = 0; end_a = 0; end_b = 0; limpa = 0;
        ciclos_limpeza = 0;
        for (int i = 0; i < 8; i++) modelo[i] = '0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // write-then-read
        passo(1, 3, 16'hA5A5, 0, 0, 0, 0);
        passo(0, 0, 0, 1, 3, 0, 0);
        ocioso(2);

        // bypass on same-cycle write/read
        passo(1, 5, 16'h0001, 0, 0, 0, 0);
        passo(1, 5, 16'h00FF, 1, 5, 5, 0);
        passo(0, 0, 0, 1, 5, 3, 0);

        // all rows, pairwise readback
        for (int i = 0; i < 8; i++) passo(1, 3'(i), 16'(16'h1000 + i), 0, 0, 0, 0);
        le_todos();

        // clear with concurrent write and read; traffic inside the window
        passo(1, 2, 16'hBEEF, 1, 2, 7, 1);
        for (int i = 0; i < 8; i++) passo(1, 3'(i), 16'hFFFF, 1, 3'(i), 0, (i == 3));
        le_todos();

        // reset mid-clear
        for (int i = 0; i < 8; i++) passo(1, 3'(i), 16'(16'h2000 + i), 0, 0, 0, 0);
        passo(0, 0, 0, 0, 0, 0, 1);
        ocioso(3);
        aplica_reset();
        passo(1, 6, 16'h1234, 0, 0, 0, 0);
        le_todos();
        ocioso(1);

        // reset mid-run with data loaded; rows must read back zero
        for (int i = 0; i < 8; i++) passo(1, 3'(i), 16'(16'h3000 + i), 0, 0, 0, 0);
        passo(0, 0, 0, 1, 1, 2, 0);
        aplica_reset();
        le_todos();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            passo(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 24) == 0));
        end
        ocioso(10);
        le_todos();
        ocioso(3);

        checks++;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending reads expected 0", fila.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
